// File: rtl/median_stream_filter_pkg.sv
// Shared constants and the FSM state type for the streaming median filter.
package median_stream_filter_pkg;

    localparam int DATA_W = 4;
    localparam int WIN    = 5;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/median_stream_filter_median5.sv
// Combinational median of five unsigned samples (3rd smallest, duplicates counted individually).
module MedianFinder_5num
    import median_stream_filter_pkg::WIN;
#(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] i_w0,
    input  logic [DATA_W-1:0] i_w1,
    input  logic [DATA_W-1:0] i_w2,
    input  logic [DATA_W-1:0] i_w3,
    input  logic [DATA_W-1:0] i_w4,
    output logic [DATA_W-1:0] o_median
);

    logic [DATA_W-1:0] w_v [WIN];
    logic [2:0]        w_rank;

    assign w_v[0] = i_w0;
    assign w_v[1] = i_w1;
    assign w_v[2] = i_w2;
    assign w_v[3] = i_w3;
    assign w_v[4] = i_w4;

    // Ties break on index so the five ranks form a permutation and exactly one element has rank 2.
    always_comb begin
        o_median = '0;
        w_rank   = '0;
        for (int i = 0; i < WIN; i++) begin
            w_rank = '0;
            for (int j = 0; j < WIN; j++) begin
                if (j != i && (w_v[j] < w_v[i] || (w_v[j] == w_v[i] && j < i))) begin
                    w_rank = w_rank + 3'd1;
                end
            end
            if (w_rank == 3'd2) begin
                o_median = w_v[i];
            end
        end
    end

endmodule

// File: rtl/median_stream_filter.sv
// Streaming 5-sample median filter with valid/ready handshake on both sides and a handoff counter.
module median_stream_filter #(
    parameter int DATA_W = median_stream_filter_pkg::DATA_W,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_median,
    output logic [CNT_W-1:0]  out_cnt
);
    import median_stream_filter_pkg::*;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_fill;
    logic [DATA_W-1:0] r_win [WIN];
    logic [DATA_W-1:0] w_win_nxt [WIN];
    logic [DATA_W-1:0] r_median;
    logic [DATA_W-1:0] w_median;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_accept;
    logic              w_handoff;
    logic              w_load;

    assign out_valid  = (r_state == HOLD);
    assign in_ready   = !(out_valid && !out_ready);
    assign w_accept   = in_valid && in_ready && !clr;
    assign w_handoff  = out_valid && out_ready;
    assign out_median = r_median;
    assign out_cnt    = r_cnt;

    // The median is taken over the post-shift window so a result appears one cycle after acceptance.
    always_comb begin
        w_win_nxt[0] = in_data;
        for (int i = 1; i < WIN; i++) begin
            w_win_nxt[i] = r_win[i-1];
        end
    end

    MedianFinder_5num #(
        .DATA_W(DATA_W)
    ) u_median (
        .i_w0    (w_win_nxt[0]),
        .i_w1    (w_win_nxt[1]),
        .i_w2    (w_win_nxt[2]),
        .i_w3    (w_win_nxt[3]),
        .i_w4    (w_win_nxt[4]),
        .o_median(w_median)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        if (clr) begin
            w_state_nxt = FILL;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_accept && r_fill == 3'(WIN - 1)) begin
                        w_state_nxt = HOLD;
                        w_load      = 1'b1;
                    end
                end
                RUN: begin
                    if (w_accept) begin
                        w_state_nxt = HOLD;
                        w_load      = 1'b1;
                    end
                end
                HOLD: begin
                    if (w_accept) begin
                        w_load = 1'b1;
                    end else if (w_handoff) begin
                        w_state_nxt = RUN;
                    end
                end
                default: w_state_nxt = FILL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= FILL;
            r_fill   <= '0;
            r_win    <= '{default: '0};
            r_median <= '0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (clr) begin
                r_fill <= '0;
            end else if (w_accept) begin
                r_win <= w_win_nxt;
                if (r_fill != 3'(WIN)) begin
                    r_fill <= r_fill + 3'd1;
                end
            end
            if (w_load) begin
                r_median <= w_median;
            end
            if (w_handoff && !clr) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/median_stream_filter.md
MEDIAN_STREAM_FILTER -- requirements
Module: median_stream_filter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, meaning sample width; only 4 is supported.
REQ-002 The block SHALL have parameter CNT_W, default 8, meaning width of the produced-result counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port clr, input, 1 bit: synchronous window flush.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts in_data this cycle.
REQ-008 The block SHALL have port in_data, input, DATA_W bits: unsigned input sample.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_median holds a valid result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes out_median this cycle.
REQ-011 The block SHALL have port out_median, output, DATA_W bits: median of the 5 most recent accepted samples.
REQ-012 The block SHALL have port out_cnt, output, CNT_W bits: number of results handed off, wrapping.

Function
REQ-013 The block SHALL treat a sample as accepted only in a cycle where in_valid=1, in_ready=1 and clr=0.
REQ-014 The block SHALL drive in_ready = !(out_valid && !out_ready), combinationally.
- Input is accepted in the same cycle as an output handoff.
REQ-015 On acceptance, the block SHALL shift window w0..w4: w0 takes in_data, and each wi takes w(i-1).
REQ-016 The block SHALL keep fill count fill in 0..5, incremented on each acceptance and saturating at 5.
REQ-017 The block SHALL implement these FSM states:
- FILL (fill<5, out_valid=0).
- RUN (window full, no pending result).
- HOLD (result pending, out_valid=1).
REQ-018 The block SHALL apply these FSM transitions:
- FILL->HOLD when the 5th sample is accepted.
- RUN->HOLD on any acceptance.
- HOLD->RUN on handoff with no acceptance.
- HOLD->HOLD on stall, or on handoff with simultaneous acceptance (new result loaded).
REQ-019 The block SHALL update out_median in the cycle after the accepting edge (latency 1) with the median of the post-shift window.
REQ-020 While out_valid=1 and out_ready=0, the block SHALL hold out_median and out_valid stable.
REQ-021 The block SHALL increment out_cnt by 1, modulo 2^CNT_W, on every cycle with out_valid=1 and out_ready=1.
REQ-022 The median SHALL be the 3rd smallest of the 5 unsigned values, with duplicates counted individually.
REQ-023 When clr=1, the block SHALL at the next edge apply all of the following:
- Set fill=0, state=FILL, out_valid=0.
- Discard that cycle's input.
- Keep out_cnt unchanged.
- Take priority over acceptance and handoff.
REQ-024 After clr or reset, the block SHALL produce no result until 5 new samples are accepted; old window contents never contribute.

Reset
REQ-025 On reset=1 at a rising edge, the block SHALL apply all of the following:
- state=FILL, fill=0, w0..w4=0.
- out_valid=0, out_median=0, out_cnt=0.
REQ-026 The block SHALL give reset priority over clr and over all handshake activity, including a reset mid-stall.
REQ-027 During reset, the block SHALL drive in_ready=1, since out_valid=0.

Structure
REQ-028 A shared package SHALL hold:
- DATA_W.
- Window depth constant WIN=5.
- The FSM state type {FILL, RUN, HOLD}.
REQ-029 The block SHALL instantiate exactly one sub-module, the team's existing combinational MedianFinder_5num, fed by w0..w4.
REQ-030 The block SHALL register the sub-module output into out_median.

Verification
REQ-031 The bench SHALL cover basic fill: accept 3,9,1,7,5 on consecutive cycles with out_ready=1.
- Required: out_valid=1, out_median=5 one cycle after the 5th sample; out_cnt=1 after handoff.
REQ-032 The bench SHALL cover sliding: after REQ-031, accept 0, then 2.
- Required results: 5 (window 9,1,7,5,0), then 2 (window 1,7,5,0,2); out_cnt=3.
REQ-033 The bench SHALL cover backpressure: hold out_ready=0 for 3 cycles with a result pending and in_valid=1.
- Required: in_ready=0; out_median constant; no shift; exactly one handoff when out_ready returns to 1.
REQ-034 The bench SHALL cover duplicates and extremes.
- 4,4,4,4,4 -> 4.
- 15,15,15,15,15 -> 15.
- 0,15,0,15,0 -> 0.
REQ-035 The bench SHALL cover flush: accept 3 samples, assert clr, then accept 8,8,1,1,6.
- Required: no out_valid before the 5th post-clr sample; out_median=6 after it.
REQ-036 The bench SHALL cover reset mid-stall: assert reset while out_valid=1 and out_ready=0.
- Required at the next edge: out_valid=0, out_median=0, out_cnt=0, in_ready=1.
